// File: rtl/modem_ctrl_pkg.sv
// Shared constants for the multi-slot modem control block: register offsets,
// identification values and STATUS bit positions.
package modem_ctrl_pkg;

    localparam logic [4:0] OFF_COMMIT = 5'h10;
    localparam logic [4:0] OFF_STATUS = 5'h11;
    localparam logic [4:0] OFF_CW     = 5'h12;
    localparam logic [4:0] OFF_IRQ_EN = 5'h13;
    localparam logic [4:0] OFF_ID     = 5'h1C;
    localparam logic [4:0] OFF_VER    = 5'h1D;
    localparam logic [4:0] OFF_NSLOT  = 5'h1E;
    localparam logic [4:0] OFF_ABORT  = 5'h1F;

    localparam logic [7:0] ID_VAL  = 8'h96;
    localparam logic [7:0] VER_VAL = 8'h02;

    localparam int ST_BUSY = 0;
    localparam int ST_FULL = 1;
    localparam int ST_ERR  = 2;
    localparam int ST_DONE = 3;

    // Index of the highest set bit; only meaningful when exactly one bit is set.
    function automatic logic [2:0] onehot_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (v[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/modem_ctrl_mslot_slot_queue.sv
// FIFO of committed slot indices; push and pop may happen in the same cycle,
// flush empties it immediately.
module slot_queue #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             pop,
    input  logic             flush,
    output logic [IDX_W-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= nxt(wr_ptr);
            if (pop_ok)  rd_ptr <= nxt(rd_ptr);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_idx;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/modem_ctrl_mslot.sv
// Multi-slot modem control register block between the SPI slave and TX engine.
// Optional interrupt output and IRQ_EN register enabled by MODEM_CTRL_IRQ_EN.
module modem_ctrl_mslot #(
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 10,
    parameter int NUM_SLOTS  = 2,
    parameter int SLOT_BYTES = 256,
    parameter int REG_BASE   = 2**ADDR_W - 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_bus_wr,
    input  logic              i_bus_rd,
    input  logic [ADDR_W-1:0] i_bus_addr,
    input  logic [7:0]        i_bus_wdata,
    output logic [7:0]        o_bus_rdata,
    input  logic [7:0]        i_ram_rdata,
    output logic              o_ram_wr,
    output logic              o_ram_rd,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [7:0]        o_ram_wdata,
    output logic              o_transmit,
    output logic [ADDR_W-1:0] o_msg_base,
    output logic [LEN_W-1:0]  o_msg_length,
    input  logic              i_tx_done,
    output logic              o_abort,
    output logic              o_reg_cw
`ifdef MODEM_CTRL_IRQ_EN
    ,
    output logic              o_irq
`endif
);
    import modem_ctrl_pkg::*;

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [ADDR_W-1:0] REG_BASE_A = ADDR_W'(REG_BASE);
    localparam logic [ADDR_W-1:0] SLOT_END   = ADDR_W'(NUM_SLOTS * SLOT_BYTES);

    logic [LEN_W-1:0]     len [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] pending;
    logic                 err, done, gap, tx_done_d;
    logic [IDX_W-1:0]     head;
    logic                 empty, full;

    logic             is_ram, ram_prot;
    logic [4:0]       off;
    logic [IDX_W-1:0] ram_slot, len_k;
    logic             len_sel, len_hi, len_wr;
    logic [2:0]       cmt_k;
    logic             cmt_wr, cmt_ok, push, pop;
    logic             st_wr, cw_wr, abort_wr, err_set;
    logic [7:0]       rdata;

    assign is_ram   = i_bus_addr < REG_BASE_A;
    assign off      = 5'(i_bus_addr - REG_BASE_A);
    assign ram_slot = IDX_W'(i_bus_addr / ADDR_W'(SLOT_BYTES));
    // RAM beyond the last slot is scratch space and never write-protected.
    assign ram_prot = (i_bus_addr < SLOT_END) && pending[ram_slot];

    assign o_ram_wr    = i_bus_wr && is_ram && !ram_prot;
    assign o_ram_rd    = i_bus_rd && is_ram;
    assign o_ram_addr  = i_bus_addr;
    assign o_ram_wdata = i_bus_wdata;

    assign len_sel = !is_ram && !off[4] && (32'(off[3:1]) < NUM_SLOTS);
    assign len_k   = IDX_W'(off[3:1]);
    assign len_hi  = !off[0];
    assign len_wr  = i_bus_wr && len_sel;

    assign cmt_k  = onehot_idx(i_bus_wdata);
    assign cmt_wr = i_bus_wr && !is_ram && (off == OFF_COMMIT);
    assign cmt_ok = $onehot(i_bus_wdata) && (32'(cmt_k) < NUM_SLOTS)
                    && !pending[IDX_W'(cmt_k)] && (len[IDX_W'(cmt_k)] != '0);
    assign push   = cmt_wr && cmt_ok;
    assign pop    = tx_done_d && !empty;

    assign st_wr    = i_bus_wr && !is_ram && (off == OFF_STATUS);
    assign cw_wr    = i_bus_wr && !is_ram && (off == OFF_CW);
    assign abort_wr = i_bus_wr && !is_ram && (off == OFF_ABORT) && i_bus_wdata[0];
    assign err_set  = (i_bus_wr && is_ram && ram_prot)
                    || (len_wr && pending[len_k])
                    || (cmt_wr && !cmt_ok);

    slot_queue #(.DEPTH(NUM_SLOTS), .IDX_W(IDX_W)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_idx (IDX_W'(cmt_k)),
        .pop      (pop),
        .flush    (abort_wr),
        .head     (head),
        .empty    (empty),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) len[k] <= '0;
            pending   <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            gap       <= 1'b0;
            tx_done_d <= 1'b0;
            o_abort   <= 1'b0;
            o_reg_cw  <= 1'b0;
        end else begin
            tx_done_d <= i_tx_done;
            o_abort   <= abort_wr;
            // One idle cycle after each completion lets the TX engine see a fresh start.
            gap       <= pop && !abort_wr;
            if (len_wr && !pending[len_k]) begin
                if (len_hi) len[len_k][LEN_W-1:8] <= i_bus_wdata[LEN_W-9:0];
                else        len[len_k][7:0]       <= i_bus_wdata;
            end
            if (cw_wr) o_reg_cw <= i_bus_wdata[0];
            if (st_wr && i_bus_wdata[ST_ERR])  err  <= 1'b0;
            if (st_wr && i_bus_wdata[ST_DONE]) done <= 1'b0;
            if (err_set) err  <= 1'b1;
            if (pop)     done <= 1'b1;
            if (pop)  pending[head] <= 1'b0;
            if (push) pending[IDX_W'(cmt_k)] <= 1'b1;
            if (abort_wr) pending <= '0;
        end
    end

`ifdef MODEM_CTRL_IRQ_EN
    logic [1:0] irq_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= '0;
            o_irq  <= 1'b0;
        end else begin
            if (i_bus_wr && !is_ram && (off == OFF_IRQ_EN)) irq_en <= i_bus_wdata[1:0];
            o_irq <= (done && irq_en[0]) || (err && irq_en[1]);
        end
    end
`endif

    assign o_transmit   = !empty && !gap;
    assign o_msg_base   = ADDR_W'(32'(head) * SLOT_BYTES);
    assign o_msg_length = len[head];

    always_comb begin
        rdata = '0;
        if (is_ram) begin
            rdata = i_ram_rdata;
        end else if (len_sel) begin
            rdata = len_hi ? 8'(len[len_k][LEN_W-1:8]) : len[len_k][7:0];
        end else begin
            case (off)
                OFF_COMMIT: rdata = 8'(pending);
                OFF_STATUS: begin
                    rdata[ST_BUSY] = o_transmit;
                    rdata[ST_FULL] = full;
                    rdata[ST_ERR]  = err;
                    rdata[ST_DONE] = done;
                end
                OFF_CW:     rdata[0] = o_reg_cw;
`ifdef MODEM_CTRL_IRQ_EN
                OFF_IRQ_EN: rdata = 8'(irq_en);
`else
                OFF_IRQ_EN: rdata = 8'h00;
`endif
                OFF_ID:     rdata = ID_VAL;
                OFF_VER:    rdata = VER_VAL;
                OFF_NSLOT:  rdata = 8'(NUM_SLOTS);
                default:    rdata = 8'h00;
            endcase
        end
    end

    assign o_bus_rdata = rdata;

endmodule

// File: doc/modem_ctrl_mslot.md
Name: modem_ctrl_mslot

Overview:
Next-generation modem control register block, placed between the SPI slave bus and the TX engine.
- Splits the packet RAM into NUM_SLOTS message slots, each with its own length register.
- Queues committed slots in FIFO order and hands them one at a time to the transmitter.
- Adds sticky status, write protection of busy slots, abort, and an optional interrupt.

Parameters:
ADDR_W, 10, SPI bus address width
LEN_W, 10, message length width in bytes
NUM_SLOTS, 2, number of message slots; power of two, 1..8
SLOT_BYTES, 256, bytes per slot; slot k base = k*SLOT_BYTES; NUM_SLOTS*SLOT_BYTES <= REG_BASE
REG_BASE, 2**ADDR_W-32, first register address; addresses below it are RAM, addresses at or above it are registers

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
i_bus_wr  in  1  single-cycle write strobe from SPI slave
i_bus_rd  in  1  single-cycle read strobe from SPI slave
i_bus_addr  in  ADDR_W  bus address
i_bus_wdata  in  8  write data
o_bus_rdata  out  8  read data, combinational from i_bus_addr
i_ram_rdata  in  8  RAM read data
o_ram_wr  out  1  RAM write strobe
o_ram_rd  out  1  RAM read strobe
o_ram_addr  out  ADDR_W  equals i_bus_addr
o_ram_wdata  out  8  equals i_bus_wdata
o_transmit  out  1  head-of-queue message valid
o_msg_base  out  ADDR_W  head slot base address
o_msg_length  out  LEN_W  head slot length
i_tx_done  in  1  one-cycle pulse from TX engine: message finished
o_abort  out  1  one-cycle abort pulse to TX engine
o_reg_cw  out  1  continuous-wave test mode
o_irq  out  1  interrupt (only with MODEM_CTRL_IRQ_EN)

Behaviour:
Register map; offsets are from REG_BASE:
- 0x00+2k / 0x01+2k: LEN[k] high bits (LEN_W-8 bits) / low 8 bits.
- 0x10: COMMIT. Write: bit k queues slot k. Read: PENDING mask.
- 0x11: STATUS. Bit0 busy (=o_transmit), bit1 queue full, bit2 ERR sticky, bit3 DONE sticky. Bits 2 and 3 are write-1-to-clear.
- 0x12: CW, bit0.
- 0x13: IRQ_EN (optional feature).
- 0x1C: ID 0x96. 0x1D: version 0x02. 0x1E: NUM_SLOTS.
- 0x1F: ABORT. Writing bit0=1 triggers abort.
- Unmapped offsets read 0; writes to them are ignored.

Reads and RAM forwarding:
- RAM read: o_ram_rd = i_bus_rd & addr<REG_BASE; o_bus_rdata = i_ram_rdata.
- RAM write: o_ram_wr = i_bus_wr & addr<REG_BASE & slot not pending. If the slot is pending, the write is suppressed and ERR is set.
- RAM addresses at or above NUM_SLOTS*SLOT_BYTES are treated as unprotected.

Length write:
- A write to LEN[k] while PENDING[k] is ignored and sets ERR.

Commit:
- Valid only if exactly one bit k is set, PENDING[k]=0 and LEN[k]!=0.
- On a valid commit: push k onto the queue and set PENDING[k].
- Otherwise: nothing is queued and ERR is set.
- Because a slot can only be pending once, the queue can never overflow.

Transmit:
- o_transmit = queue non-empty and no gap cycle.
- o_msg_base and o_msg_length are driven from the queue head.
- Commit write at edge N on an idle block gives o_transmit=1 after edge N.

Completion:
- i_tx_done is registered once (registered copy is tx_done_d).
- tx_done_d high at edge E: pop the head, clear its PENDING bit, set DONE, drop o_transmit for exactly one cycle.
- o_transmit re-asserts after edge E+1 if the queue is still non-empty.
- i_tx_done while the queue is empty is ignored.

Simultaneous events:
- Commit and pop in the same cycle: both take effect.
- Commit of the slot currently in flight: ERR.

Abort:
- o_abort pulses 1 cycle.
- Next edge: queue flushed, PENDING=0, o_transmit=0. LEN and CW are kept.

Reset:
- All registers, queue, PENDING, ERR, DONE, CW and IRQ_EN go to 0.
- o_transmit, o_abort and o_irq are 0 after the first edge with reset high, including mid-message.

Optional Feature:
MODEM_CTRL_IRQ_EN
- Defined: IRQ_EN register exists (bit0 DONE enable, bit1 ERR enable); o_irq = (DONE&IRQ_EN[0]) | (ERR&IRQ_EN[1]), registered.
- Undefined: o_irq port is absent; offset 0x13 reads 0 and ignores writes.

Decomposition:
- Package modem_ctrl_pkg: register offsets, ID/version constants, STATUS bit indices.
- Sub-module slot_queue: FIFO of slot indices, depth NUM_SLOTS.
  - Supports simultaneous push/pop.
  - Outputs: head, empty, full, and a flush input.

Test Plan:
- Reset, then read 0x1C/0x1D/0x1E -> 0x96/0x02/0x02; STATUS=0; o_transmit=0.
- Write LEN0=300, COMMIT=0x01 -> o_transmit=1, o_msg_base=0, o_msg_length=300 the next cycle; RAM write to address 5 suppressed; ERR=1.
- Commit slot0 then slot1, pulse i_tx_done -> o_transmit low exactly 1 cycle, then base=256; second done -> idle; DONE=1; PENDING=0.
- COMMIT=0x03, commit with LEN=0, and re-commit of a pending slot -> each sets ERR with nothing queued; W1C 0x04 to STATUS clears ERR.
- Commit in the same cycle as the registered done -> push and pop both occur; queue order is kept.
- ABORT mid-message and reset mid-message -> o_abort 1-cycle pulse, queue empty, o_transmit=0; with IRQ_EN=0x01, DONE raises o_irq.
